// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS frequency-sweep sequencer.
//   - Sweep mode encodings (MODE_SINGLE / MODE_SAW / MODE_TRI; 2'b11 acts as
//     single because it is neither repeat encoding).
//   - Sweep FSM state enum.
//   - isRepeat(): true for the modes that loop until stopped.
// ---------------------------------------------------------------------------
package dds_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } sweep_state_e;

    function automatic logic isRepeat(input logic [1:0] m);
        return (m == MODE_SAW) || (m == MODE_TRI);
    endfunction

endpackage

// File: rtl/dds_sweep_step.sv
// ---------------------------------------------------------------------------
// dds_sweep_step
// Combinational next-point calculator for the sweep sequencer.
// Ports:
//   cur    in  N  current frequency word
//   inc    in  N  step magnitude
//   target in  N  endpoint of the current leg
//   dir    in  1  1 = step upwards, 0 = step downwards
//   next   out N  next frequency word, clamped to target
//   hit    out 1  next equals target (endpoint reached)
// ---------------------------------------------------------------------------
module dds_sweep_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] cur,
    input  logic [N-1:0] inc,
    input  logic [N-1:0] target,
    input  logic         dir,
    output logic [N-1:0] next,
    output logic         hit
);

    logic [N:0] sum;
    logic [N:0] diff;

    // One extra bit catches carry-out / borrow so a step past either end of
    // the word range clamps to the target instead of wrapping.
    always_comb begin
        sum  = {1'b0, cur} + {1'b0, inc};
        diff = {1'b0, cur} - {1'b0, inc};
        next = cur;
        if (dir) begin
            if (sum[N] || (sum[N-1:0] >= target)) begin
                next = target;
            end else begin
                next = sum[N-1:0];
            end
        end else begin
            if (diff[N] || (diff[N-1:0] <= target)) begin
                next = target;
            end else begin
                next = diff[N-1:0];
            end
        end
        hit = (next == target);
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep sequencer feeding the DDS core in place of the static
// frequency/phase converter. Steps fre_step from f_start to f_stop in f_inc
// increments, holding each point dwell+1 cycles. Modes: single, sawtooth
// repeat, triangle repeat.
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start, stop       start request (IDLE only), abort (RUN/LAST)
//   mode              sweep mode (see dds_pkg)
//   f_start, f_stop   sweep endpoints; f_stop < f_start sweeps down
//   f_inc, dwell      step magnitude, extra hold cycles per point
//   pha_cfg, wave_cfg phase word / waveform select for the whole sweep
//   fre_step, pha_step, wave_sel   registered outputs to the DDS core
//   busy              high in RUN/LAST
//   done              one-cycle pulse at normal end of a single sweep
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int N       = 32,
    parameter int M       = 12,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       f_start,
    input  logic [N-1:0]       f_stop,
    input  logic [N-1:0]       f_inc,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [M-1:0]       pha_cfg,
    input  logic [3:0]         wave_cfg,
    output logic [N-1:0]       fre_step,
    output logic [M-1:0]       pha_step,
    output logic [3:0]         wave_sel,
    output logic               busy,
    output logic               done
);

    sweep_state_e       state_q, state_d;
    logic [N-1:0]       fre_q, fre_d;
    logic [M-1:0]       pha_q, pha_d;
    logic [3:0]         wave_q, wave_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               dirUp_q, dirUp_d;
    logic               leg_q, leg_d;
    logic               atEnd_q, atEnd_d;
    logic [1:0]         mode_q, mode_d;
    logic [N-1:0]       fStart_q, fStart_d;
    logic [N-1:0]       fStop_q, fStop_d;
    logic [N-1:0]       inc_q, inc_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               legEff;
    logic [N-1:0]       stepTarget;
    logic               stepDir;
    logic [N-1:0]       stepNext;
    logic               stepHit;

    // leg_q=0 is the forward leg (towards f_stop), 1 the triangle return leg.
    // When the triangle sits on an endpoint the following step already uses
    // the flipped leg, so the endpoint is shown only once per turn.
    always_comb begin
        legEff     = (atEnd_q && (mode_q == MODE_TRI)) ? ~leg_q : leg_q;
        stepTarget = legEff ? fStart_q : fStop_q;
        stepDir    = dirUp_q ^ legEff;
    end

    dds_sweep_step #(.N(N)) uStep (
        .cur    (fre_q),
        .inc    (inc_q),
        .target (stepTarget),
        .dir    (stepDir),
        .next   (stepNext),
        .hit    (stepHit)
    );

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        fre_d    = fre_q;
        pha_d    = pha_q;
        wave_d   = wave_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        dirUp_d  = dirUp_q;
        leg_d    = leg_q;
        atEnd_d  = atEnd_q;
        mode_d   = mode_q;
        fStart_d = fStart_q;
        fStop_d  = fStop_q;
        inc_d    = inc_q;
        dwell_d  = dwell_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mode_d   = mode;
                    fStart_d = f_start;
                    fStop_d  = f_stop;
                    inc_d    = f_inc;
                    dwell_d  = dwell;
                    dirUp_d  = (f_stop >= f_start);
                    fre_d    = f_start;
                    pha_d    = pha_cfg;
                    wave_d   = wave_cfg;
                    cnt_d    = dwell;
                    leg_d    = 1'b0;
                    atEnd_d  = 1'b0;
                    // A single sweep with nothing to step is just one point.
                    if (!isRepeat(mode) && ((f_inc == '0) || (f_start == f_stop))) begin
                        state_d = LAST;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d = dwell_q;
                    if (atEnd_q && (mode_q == MODE_SAW)) begin
                        fre_d   = fStart_q;
                        atEnd_d = 1'b0;
                    end else begin
                        fre_d   = stepNext;
                        leg_d   = legEff;
                        atEnd_d = stepHit;
                        if (stepHit && !isRepeat(mode_q)) begin
                            state_d = LAST;
                        end
                    end
                end
            end
            LAST: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            fre_q    <= '0;
            pha_q    <= '0;
            wave_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            dirUp_q  <= 1'b1;
            leg_q    <= 1'b0;
            atEnd_q  <= 1'b0;
            mode_q   <= MODE_SINGLE;
            fStart_q <= '0;
            fStop_q  <= '0;
            inc_q    <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            fre_q    <= fre_d;
            pha_q    <= pha_d;
            wave_q   <= wave_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            dirUp_q  <= dirUp_d;
            leg_q    <= leg_d;
            atEnd_q  <= atEnd_d;
            mode_q   <= mode_d;
            fStart_q <= fStart_d;
            fStop_q  <= fStop_d;
            inc_q    <= inc_d;
            dwell_q  <= dwell_d;
        end
    end

    assign fre_step = fre_q;
    assign pha_step = pha_q;
    assign wave_sel = wave_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Directed bench for dds_sweep_ctrl with hand-computed expected sequences.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_inc;
    logic [15:0] dwell;
    logic [11:0] pha_cfg;
    logic [3:0]  wave_cfg;
    logic [31:0] fre_step;
    logic [11:0] pha_step;
    logic [3:0]  wave_sel;
    logic        busy;
    logic        done;

    int          errCount;
    int          checkCount;
    logic [31:0] expPts [8];

    dds_sweep_ctrl #(.N(32), .M(12), .DWELL_W(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .f_start  (f_start),
        .f_stop   (f_stop),
        .f_inc    (f_inc),
        .dwell    (dwell),
        .pha_cfg  (pha_cfg),
        .wave_cfg (wave_cfg),
        .fre_step (fre_step),
        .pha_step (pha_step),
        .wave_sel (wave_sel),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a configuration with a one-cycle start; returns in cycle t+1.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] fs,
                                 input logic [31:0] fe, input logic [31:0] inc,
                                 input logic [15:0] dw, input logic [11:0] pha,
                                 input logic [3:0] wave);
        mode     = m;
        f_start  = fs;
        f_stop   = fe;
        f_inc    = inc;
        dwell    = dw;
        pha_cfg  = pha;
        wave_cfg = wave;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Walk a single sweep of nPts points from expPts, then check done.
    task automatic checkSweep(input string tag, input int nPts, input int dw);
        for (int k = 0; k < nPts; k++) begin
            for (int j = 0; j <= dw; j++) begin
                checkOutput({tag, " fre"}, 64'(fre_step), 64'(expPts[k]));
                checkOutput({tag, " busy"}, 64'(busy), 64'd1);
                checkOutput({tag, " done"}, 64'(done), 64'd0);
                tick();
            end
        end
        checkOutput({tag, " done end"}, 64'(done), 64'd1);
        checkOutput({tag, " busy end"}, 64'(busy), 64'd0);
        checkOutput({tag, " fre end"}, 64'(fre_step), 64'(expPts[nPts-1]));
        tick();
        checkOutput({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rstn       = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        mode       = 2'b00;
        f_start    = '0;
        f_stop     = '0;
        f_inc      = '0;
        dwell      = '0;
        pha_cfg    = '0;
        wave_cfg   = '0;

        #12;
        checkOutput("reset fre", 64'(fre_step), 64'd0);
        checkOutput("reset pha", 64'(pha_step), 64'd0);
        checkOutput("reset wave", 64'(wave_sel), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        rstn = 1'b1;
        tick();
        tick();

        // Up, single
        applyStimulus(2'b00, 32'd100, 32'd130, 32'd10, 16'd2, 12'h3A5, 4'h9);
        checkOutput("up pha", 64'(pha_step), 64'h3A5);
        checkOutput("up wave", 64'(wave_sel), 64'h9);
        expPts[0] = 32'd100; expPts[1] = 32'd110; expPts[2] = 32'd120; expPts[3] = 32'd130;
        checkSweep("up", 4, 2);
        checkOutput("idle hold pha", 64'(pha_step), 64'h3A5);

        // Down with clamp
        applyStimulus(2'b00, 32'd100, 32'd75, 32'd10, 16'd0, 12'h001, 4'h1);
        expPts[0] = 32'd100; expPts[1] = 32'd90; expPts[2] = 32'd80; expPts[3] = 32'd75;
        checkSweep("down", 4, 0);

        // Overflow clamp, mode 11 behaves as single
        applyStimulus(2'b11, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 12'h002, 4'h2);
        expPts[0] = 32'hFFFF_FFF0; expPts[1] = 32'hFFFF_FFFF;
        checkSweep("ovf", 2, 0);

        // Triangle, then stop
        applyStimulus(2'b10, 32'd0, 32'd20, 32'd10, 16'd0, 12'h003, 4'h3);
        expPts[0] = 32'd0;  expPts[1] = 32'd10; expPts[2] = 32'd20; expPts[3] = 32'd10;
        expPts[4] = 32'd0;  expPts[5] = 32'd10; expPts[6] = 32'd20; expPts[7] = 32'd10;
        for (int i = 0; i < 8; i++) begin
            checkOutput("tri fre", 64'(fre_step), 64'(expPts[i]));
            checkOutput("tri busy", 64'(busy), 64'd1);
            if (i < 7) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("tri stop busy", 64'(busy), 64'd0);
        checkOutput("tri stop fre", 64'(fre_step), 64'd10);
        checkOutput("tri stop done", 64'(done), 64'd0);
        tick();
        checkOutput("tri idle done", 64'(done), 64'd0);
        checkOutput("tri idle fre", 64'(fre_step), 64'd10);

        // Sawtooth with config changed mid-sweep
        applyStimulus(2'b01, 32'd5, 32'd15, 32'd10, 16'd1, 12'h123, 4'h5);
        mode     = 2'b00;
        f_start  = 32'd999;
        f_stop   = 32'd7;
        f_inc    = 32'd1;
        dwell    = 16'd0;
        pha_cfg  = 12'h000;
        wave_cfg = 4'h0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("saw fre", 64'(fre_step), (((i / 2) % 2) == 1) ? 64'd15 : 64'd5);
            checkOutput("saw pha", 64'(pha_step), 64'h123);
            checkOutput("saw wave", 64'(wave_sel), 64'h5);
            tick();
        end
        // Start while busy is ignored
        checkOutput("saw p9 fre", 64'(fre_step), 64'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy start fre", 64'(fre_step), 64'd5);
        checkOutput("busy start busy", 64'(busy), 64'd1);
        checkOutput("busy start pha", 64'(pha_step), 64'h123);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("saw stop busy", 64'(busy), 64'd0);
        checkOutput("saw stop fre", 64'(fre_step), 64'd5);

        // Start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("start+stop busy", 64'(busy), 64'd0);
        checkOutput("start+stop fre", 64'(fre_step), 64'd5);
        tick();
        checkOutput("start+stop busy2", 64'(busy), 64'd0);

        // Zero increment single
        applyStimulus(2'b00, 32'd42, 32'd80, 32'd0, 16'd3, 12'h004, 4'h4);
        expPts[0] = 32'd42;
        checkSweep("inc0", 1, 3);

        // Reset mid-sweep, then restart
        applyStimulus(2'b00, 32'd100, 32'd130, 32'd10, 16'd2, 12'h3A5, 4'h9);
        tick();
        tick();
        tick();
        checkOutput("pre reset fre", 64'(fre_step), 64'd110);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("mid reset fre", 64'(fre_step), 64'd0);
        checkOutput("mid reset pha", 64'(pha_step), 64'd0);
        checkOutput("mid reset wave", 64'(wave_sel), 64'd0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("post reset busy", 64'(busy), 64'd0);
        applyStimulus(2'b00, 32'd100, 32'd75, 32'd10, 16'd0, 12'h001, 4'h1);
        expPts[0] = 32'd100; expPts[1] = 32'd90; expPts[2] = 32'd80; expPts[3] = 32'd75;
        checkSweep("restart", 4, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. Drives the core's `fre_step`, `pha_step` and `wave_sel` inputs in place of the static frequency/phase converter. It steps the phase-accumulator increment from a start word to a stop word in fixed increments, holding each point for a programmable dwell. It supports single-shot, sawtooth-repeat and triangle-repeat sweeps with start/stop control.

## Interface
- `N`, 32, phase-accumulator (frequency word) width
- `M`, 12, phase-offset word width
- `DWELL_W`, 16, dwell counter width

- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request; honoured only in IDLE
- `stop`  in  1  abort; honoured in any active state
- `mode`  in  2  00 single, 01 sawtooth repeat, 10 triangle repeat, 11 treated as single
- `f_start`  in  N  first frequency word
- `f_stop`  in  N  last frequency word; f_stop < f_start means a down-sweep
- `f_inc`  in  N  step magnitude
- `dwell`  in  DWELL_W  extra hold cycles per point; each point lasts dwell+1 cycles
- `pha_cfg`  in  M  phase word applied for the whole sweep
- `wave_cfg`  in  4  waveform select applied for the whole sweep
- `fre_step`  out  N  frequency word to the DDS core
- `pha_step`  out  M  phase word to the DDS core
- `wave_sel`  out  4  waveform select to the DDS core
- `busy`  out  1  high in RUN/LAST
- `done`  out  1  one-cycle pulse at normal completion of a single sweep

## Operation
- States: IDLE, RUN (intermediate points), LAST (final point of a single sweep).
- IDLE, `start`=1, `stop`=0:
  - latch all config inputs and set `dir` = (f_stop >= f_start) ? up : down
  - load `fre_step`=f_start, `pha_step`=pha_cfg, `wave_sel`=wave_cfg, dwell counter=dwell
  - go to RUN; `busy`=1
- RUN: the counter decrements each cycle. At counter==0 it reloads with dwell and `fre_step` takes the next point.
- Next point is computed with (N+1)-bit arithmetic:
  - up: sum = cur+inc; if carry or sum >= target, then next = target (clamp)
  - down: diff = cur−inc; if borrow or diff <= target, then next = target
  - target is f_stop on the forward leg and f_start on the triangle return leg
- Reaching an endpoint (next == target):
  - single: enter LAST holding target
  - sawtooth: after target's dwell, next = f_start
  - triangle: after target's dwell, flip the leg and step toward the other endpoint
- LAST: after dwell+1 cycles go to IDLE; `done`=1 for one cycle; `busy`=0 in the same cycle.
- Degenerate case, f_inc==0 or f_start==f_stop:
  - single: f_start is the only point; enter LAST directly with f_start and dwell counter=dwell
  - repeat modes: hold f_start until `stop`
- `stop` in RUN/LAST: go to IDLE next cycle; `busy`=0, no `done`; `fre_step`/`pha_step`/`wave_sel` hold their last values.
- `start` while busy is ignored. `start` and `stop` together in IDLE: stop wins, nothing starts.
- Config inputs are sampled only at accepted `start`; later changes have no effect mid-sweep.
- In IDLE all outputs hold; reset is the only way to zero them.

## Timing
- Reset values: `fre_step`=0, `pha_step`=0, `wave_sel`=0, `busy`=0, `done`=0, state=IDLE, `dir`=up.
- `start` accepted in cycle t: first point is visible at t+1. Point k is visible from t+1+k·(dwell+1).
- Single sweep of P points: `done` is high and `busy` low at t+1+P·(dwell+1).
- `stop` sampled high in cycle s: `busy`=0 at s+1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-sweep returns all outputs to reset values immediately, because reset is asynchronous.

## Structure
- Shared package `dds_pkg` holds:
  - mode encodings: MODE_SINGLE, MODE_SAW, MODE_TRI
  - sweep state enum: IDLE, RUN, LAST
- Sub-module `dds_sweep_step`, purely combinational: inputs cur, inc, target, dir; outputs next and `hit`. It owns all carry/borrow/clamp logic.
- The top level holds the FSM, dwell counter, leg flag and config registers.
- Drop-in replacement for the frequency/phase converter feeding `wave_ctrl`.

## Test plan
- Up, single: f_start=100, f_stop=130, f_inc=10, dwell=2, start at t → `fre_step` 100/110/120/130, each for 3 cycles from t+1; `done` at t+13.
- Down with clamp: f_start=100, f_stop=75, f_inc=10, dwell=0 → 100, 90, 80, 75; `done` at t+5.
- Overflow clamp: f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_inc=0x20, dwell=0 → 0xFFFFFFF0 then 0xFFFFFFFF (no wrap to 0x10); `done` at t+3.
- Triangle: f_start=0, f_stop=20, f_inc=10, dwell=0 → 0, 10, 20, 10, 0, 10, 20 …; stop at s → `busy`=0 at s+1, value held, no `done`.
- Sawtooth: f_start=5, f_stop=15, f_inc=10, dwell=1 → 5, 5, 15, 15, 5, 5 …; `pha_step`/`wave_sel` equal pha_cfg/wave_cfg throughout. Config changed mid-sweep has no effect.
- Control corners:
  - `start` while busy is ignored
  - start+stop together in IDLE: nothing starts
  - f_inc=0 single with dwell=3 → f_start for 4 cycles, then `done`
  - `rstn` low mid-sweep → all outputs 0 at once; restart after release works
